// File: rtl/reduce_threshold_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : reduce_threshold_ctrl_pkg
//  Description : Shared definitions for the HSV threshold sequencer and the
//                colour-reduction stage (field codes, FSM codes, mask helper).
//  Revision    : 1.0 - initial release
// ============================================================================
package reduce_threshold_ctrl_pkg;

    localparam int DATA_W_DEF = 8;

    // Selected-field encodings
    localparam logic [1:0] FIELD_H = 2'd0;
    localparam logic [1:0] FIELD_S = 2'd1;
    localparam logic [1:0] FIELD_V = 2'd2;

    // Controller state encodings
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_EDIT  = 2'd1;
    localparam logic [1:0] ST_SWEEP = 2'd2;

    // Right-aligned mask of 'width' bits whose top 'lvl' bits are ones.
    // Callers size-cast the result down to their own channel width.
    function automatic logic [31:0] level_to_mask(input int width, input int lvl);
        logic [31:0] m;
        m = '0;
        for (int i = 0; i < 32; i++) begin
            if ((i < width) && (i + lvl >= width)) begin
                m[i] = 1'b1;
            end
        end
        return m;
    endfunction

endpackage
`default_nettype wire

// File: rtl/reduce_threshold_ctrl_thr_level_reg.sv
`default_nettype none
// ============================================================================
//  Module      : thr_level_reg
//  Description : One channel's working/active level pair with saturating
//                edit, wrap-around decrement, commit, discard and a
//                registered mask derived from the active level.
//  Revision    : 1.0 - initial release
// ============================================================================
module thr_level_reg
    import reduce_threshold_ctrl_pkg::*;
#(
    parameter int DATA_W  = DATA_W_DEF,
    parameter int RST_LVL = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              i_inc,
    input  logic              i_dec,
    input  logic              i_wrapDec,
    input  logic              i_commit,
    input  logic              i_discard,
    output logic [DATA_W-1:0] o_mask,
    output logic              o_diffNext
);

    localparam int LVL_W = $clog2(DATA_W + 1);
    localparam logic [LVL_W-1:0] c_MAX = LVL_W'(DATA_W);
    localparam logic [LVL_W-1:0] c_MIN = LVL_W'(1);
    localparam logic [LVL_W-1:0] c_RST = LVL_W'(RST_LVL);

    logic [LVL_W-1:0]  r_work;
    logic [LVL_W-1:0]  r_act;
    logic [DATA_W-1:0] r_mask;
    logic [LVL_W-1:0]  w_workEdit;
    logic [LVL_W-1:0]  w_actWrap;
    logic [LVL_W-1:0]  w_workNext;
    logic [LVL_W-1:0]  w_actNext;

    // Next working/active levels; discard and sweep step override edits,
    // and a commit copies the pre-edit working value.
    always_comb begin
        w_workEdit = r_work;
        if (i_inc && (r_work != c_MAX)) begin
            w_workEdit = r_work + LVL_W'(1);
        end else if (i_dec && (r_work != c_MIN)) begin
            w_workEdit = r_work - LVL_W'(1);
        end
        w_actWrap  = (r_act == c_MIN) ? c_MAX : (r_act - LVL_W'(1));
        w_workNext = w_workEdit;
        w_actNext  = r_act;
        if (i_discard) begin
            w_workNext = r_act;
        end else if (i_wrapDec) begin
            w_workNext = w_actWrap;
            w_actNext  = w_actWrap;
        end else if (i_commit) begin
            w_actNext  = r_work;
        end
    end

    assign o_diffNext = (w_workNext != w_actNext);
    assign o_mask     = r_mask;

    // Level registers; the mask is rebuilt from the next active level.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_work <= c_RST;
            r_act  <= c_RST;
            r_mask <= DATA_W'(level_to_mask(DATA_W, RST_LVL));
        end else begin
            r_work <= w_workNext;
            r_act  <= w_actNext;
            r_mask <= DATA_W'(level_to_mask(DATA_W, int'(w_actNext)));
        end
    end

endmodule
`default_nettype wire

// File: rtl/reduce_threshold_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : reduce_threshold_ctrl
//  Description : Button/auto-sweep sequencer producing H/S/V threshold masks,
//                committing edits only at frame boundaries.
//  Revision    : 1.0 - initial release
// ============================================================================
module reduce_threshold_ctrl
    import reduce_threshold_ctrl_pkg::*;
#(
    parameter int DATA_W       = DATA_W_DEF,
    parameter int SWEEP_FRAMES = 30,
    parameter int H_RST_LVL    = 4,
    parameter int S_RST_LVL    = 3,
    parameter int V_RST_LVL    = 3
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              btn_up,
    input  logic              btn_down,
    input  logic              btn_next,
    input  logic              sweep_en,
    input  logic              frame_start,
    output logic [DATA_W-1:0] hThreshold,
    output logic [DATA_W-1:0] sThreshold,
    output logic [DATA_W-1:0] vThreshold,
    output logic [1:0]        sel_field,
    output logic              pending,
    output logic [1:0]        state_dbg
);

    localparam int CNT_W = (SWEEP_FRAMES > 1) ? $clog2(SWEEP_FRAMES) : 1;
    localparam logic [CNT_W-1:0] c_CNT_LAST = CNT_W'(SWEEP_FRAMES - 1);

    logic [1:0]       r_state;
    logic [1:0]       r_sel;
    logic [CNT_W-1:0] r_cnt;
    logic             r_pending;

    logic [1:0]       w_stateNext;
    logic [1:0]       w_selNext;
    logic [CNT_W-1:0] w_cntNext;
    logic             w_editOk;
    logic             w_up;
    logic             w_down;
    logic             w_commit;
    logic             w_discard;
    logic             w_step;
    logic             w_pendNext;

    logic [DATA_W-1:0] w_mask [3];
    logic [2:0]        w_diff;

    // Shared control qualifiers: sweep request blocks every button action.
    assign w_editOk   = (r_state != ST_SWEEP) && !sweep_en;
    assign w_up       = w_editOk && btn_up && !btn_down;
    assign w_down     = w_editOk && btn_down && !btn_up;
    assign w_commit   = (r_state == ST_EDIT) && !sweep_en && frame_start && r_pending;
    assign w_discard  = (r_state == ST_EDIT) && sweep_en;
    assign w_step     = (r_state == ST_SWEEP) && sweep_en && frame_start && (r_cnt == c_CNT_LAST);
    assign w_pendNext = |w_diff;

    generate
        for (genvar g = 0; g < 3; g++) begin : g_chan
            localparam logic [1:0] c_FIELD = (g == 0) ? FIELD_H : (g == 1) ? FIELD_S : FIELD_V;
            localparam int c_RST_LVL = (g == 0) ? H_RST_LVL : (g == 1) ? S_RST_LVL : V_RST_LVL;
            thr_level_reg #(
                .DATA_W  (DATA_W),
                .RST_LVL (c_RST_LVL)
            ) u_lvl (
                .clk        (clk),
                .reset      (reset),
                .i_inc      (w_up && (r_sel == c_FIELD)),
                .i_dec      (w_down && (r_sel == c_FIELD)),
                .i_wrapDec  (w_step),
                .i_commit   (w_commit),
                .i_discard  (w_discard),
                .o_mask     (w_mask[g]),
                .o_diffNext (w_diff[g])
            );
        end
    endgenerate

    // Next-state, field select and sweep frame counter.
    always_comb begin
        w_stateNext = r_state;
        w_selNext   = r_sel;
        w_cntNext   = r_cnt;
        if (w_editOk && btn_next) begin
            w_selNext = (r_sel == FIELD_V) ? FIELD_H : (r_sel + 2'd1);
        end
        case (r_state)
            ST_IDLE: begin
                if (sweep_en) begin
                    w_stateNext = ST_SWEEP;
                end else if (btn_up || btn_down) begin
                    w_stateNext = ST_EDIT;
                end
            end
            ST_EDIT: begin
                if (sweep_en) begin
                    w_stateNext = ST_SWEEP;
                end else if (w_commit) begin
                    w_stateNext = w_pendNext ? ST_EDIT : ST_IDLE;
                end
            end
            ST_SWEEP: begin
                if (!sweep_en) begin
                    w_stateNext = ST_IDLE;
                    w_cntNext   = '0;
                end else if (frame_start) begin
                    w_cntNext = w_step ? '0 : (r_cnt + CNT_W'(1));
                end
            end
            default: begin
                w_stateNext = ST_IDLE;
            end
        endcase
    end

    // Controller state registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state   <= ST_IDLE;
            r_sel     <= FIELD_H;
            r_cnt     <= '0;
            r_pending <= 1'b0;
        end else begin
            r_state   <= w_stateNext;
            r_sel     <= w_selNext;
            r_cnt     <= w_cntNext;
            r_pending <= w_pendNext;
        end
    end

    assign hThreshold = w_mask[0];
    assign sThreshold = w_mask[1];
    assign vThreshold = w_mask[2];
    assign sel_field  = r_sel;
    assign pending    = r_pending;
    assign state_dbg  = r_state;

endmodule
`default_nettype wire
